debounce_scheduler: RTL and testbench



---
 rtl/debounce_pkg.sv | 18 +
 rtl/settle_timer.sv | 37 +++
 rtl/debounce_scheduler.sv | 137 +++++++++++++
 tb/tb_debounce_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce scheduler.
// Holds the FSM encoding, default timer sizing and the channel index-width helper.
package debounce_pkg;

  typedef logic [0:0] state_t;

  localparam state_t StIdle   = 1'b0;
  localparam state_t StTiming = 1'b1;

  localparam int unsigned DefaultCntW         = 16;
  localparam int unsigned DefaultSettleCycles = 50;

  // Width of a channel index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Shared settle counter: synchronous clear and enable, terminal flag at SETTLE_CYCLES-1.
// Clear has priority over enable; the counter never advances past the terminal value.
module settle_timer
  import debounce_pkg::*;
#(
  parameter int unsigned CNT_W         = DefaultCntW,
  parameter int unsigned SETTLE_CYCLES = DefaultSettleCycles
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  if (CNT_W < 1 || CNT_W > 31) begin : g_bad_cnt_w
    $error("settle_timer: CNT_W must be in 1..31");
  end
  if (SETTLE_CYCLES < 1 || 64'(SETTLE_CYCLES) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_settle
    $error("settle_timer: SETTLE_CYCLES must be in 1..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] TermVal = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != TermVal)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_terminal = (r_count == TermVal);

endmodule

// File: rtl/debounce_scheduler.sv
// Round-robin debounce scheduler sharing one settle timer across N_CH switch channels.
// Edge pulses exist only when DEBOUNCE_SCHED_PULSE_EN is defined; otherwise tied to 0.
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned SETTLE_CYCLES = DefaultSettleCycles,
  parameter int unsigned CNT_W         = DefaultCntW,
  localparam int unsigned OW           = idx_width(N_CH)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_CH-1:0] i_sw_sync,
  output logic [N_CH-1:0] o_clean,
  output logic [N_CH-1:0] o_rise_pulse,
  output logic [N_CH-1:0] o_fall_pulse,
  output logic            o_busy,
  output logic [OW-1:0]   o_owner
);

  if (N_CH < 2 || N_CH > 16) begin : g_bad_n_ch
    $error("debounce_scheduler: N_CH must be in 2..16");
  end

  state_t          r_state;
  logic [N_CH-1:0] r_clean;
  logic [OW-1:0]   r_owner;
  logic [OW-1:0]   r_ptr;

  logic [N_CH-1:0] w_pending;
  logic [OW-1:0]   w_grant_idx;
  logic [OW-1:0]   w_owner_next;
  logic            w_found;
  logic            w_timing;
  logic            w_abort;
  logic            w_commit;
  logic            w_terminal;
  logic            w_clear;
  logic            w_enable;

  // Level-based request: a channel keeps asking until its clean bit agrees.
  assign w_pending = i_sw_sync ^ r_clean;

  // First pending channel at or above ptr, wrapping.
  always_comb begin
    logic [OW-1:0] idx;
    w_found     = 1'b0;
    w_grant_idx = '0;
    idx         = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      idx = OW'((32'(r_ptr) + k) % N_CH);
      if (!w_found && w_pending[idx]) begin
        w_found     = 1'b1;
        w_grant_idx = idx;
      end
    end
  end

  assign w_owner_next = (r_owner == OW'(N_CH - 1)) ? '0 : r_owner + OW'(1);

  assign w_timing = (r_state == StTiming);
  assign w_abort  = w_timing && (i_sw_sync[r_owner] == r_clean[r_owner]);
  assign w_commit = w_timing && !w_abort && w_terminal;
  assign w_clear  = ((r_state == StIdle) && w_found) || w_abort;
  assign w_enable = w_timing && !w_abort;

  settle_timer #(
    .CNT_W         (CNT_W),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    (w_clear),
    .i_enable   (w_enable),
    .o_terminal (w_terminal)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_clean <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_found) begin
            r_owner <= w_grant_idx;
            r_state <= StTiming;
          end
        end
        StTiming: begin
          if (w_abort) begin
            r_state <= StIdle;
            r_ptr   <= w_owner_next;
          end else if (w_commit) begin
            r_clean[r_owner] <= i_sw_sync[r_owner];
            r_state          <= StIdle;
            r_ptr            <= w_owner_next;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef DEBOUNCE_SCHED_PULSE_EN
  logic [N_CH-1:0] r_rise;
  logic [N_CH-1:0] r_fall;

  // Registered alongside the clean bit so the pulse lands in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= '0;
      r_fall <= '0;
      if (w_commit) begin
        r_rise[r_owner] <= i_sw_sync[r_owner];
        r_fall[r_owner] <= !i_sw_sync[r_owner];
      end
    end
  end

  assign o_rise_pulse = r_rise;
  assign o_fall_pulse = r_fall;
`else
  assign o_rise_pulse = '0;
  assign o_fall_pulse = '0;
`endif

  assign o_clean = r_clean;
  assign o_busy  = w_timing;
  assign o_owner = r_owner;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Self-checking bench for debounce_scheduler (N_CH=4, SETTLE_CYCLES=50).
// Expected commits are queued when stimulus is driven and popped when clean changes.
module tb_debounce_scheduler;

  localparam int unsigned NCh    = 4;
  localparam int unsigned Settle = 50;
  localparam int unsigned CntW   = 16;

`ifdef DEBOUNCE_SCHED_PULSE_EN
  localparam bit PulseEn = 1'b1;
`else
  localparam bit PulseEn = 1'b0;
`endif

  typedef struct {
    int   cyc;
    int   ch;
    logic level;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCh-1:0] sw  = '0;
  logic [NCh-1:0] clean;
  logic [NCh-1:0] rise;
  logic [NCh-1:0] fall;
  logic           busy;
  logic [1:0]     owner;

  int             n_tests    = 0;
  int             n_fail     = 0;
  int             cyc        = 0;
  logic           rst_prev   = 1'b1;
  logic [NCh-1:0] prev_clean = '0;
  exp_t           exp_q[$];

  debounce_scheduler #(
    .N_CH          (NCh),
    .SETTLE_CYCLES (Settle),
    .CNT_W         (CntW)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_sw_sync    (sw),
    .o_clean      (clean),
    .o_rise_pulse (rise),
    .o_fall_pulse (fall),
    .o_busy       (busy),
    .o_owner      (owner)
  );

  always #5 clk = ~clk;

  // One clock; afterwards cyc is the index of the cycle now visible on the outputs.
  task automatic step();
    logic [NCh-1:0] chg;
    logic [NCh-1:0] er;
    logic [NCh-1:0] ef;
    exp_t           e;
    @(posedge clk);
    rst_prev = rst;
    cyc++;
    #1;
    if (rst_prev) begin
      n_tests++;
      if ({clean, rise, fall, busy, owner} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc=%0d got clean=%b rise=%b fall=%b busy=%b owner=%0d want all 0",
                 cyc, clean, rise, fall, busy, owner);
      end
    end else begin
      chg = clean ^ prev_clean;
      er  = PulseEn ? (chg & clean) : '0;
      ef  = PulseEn ? (chg & ~clean) : '0;
      n_tests++;
      if (rise !== er || fall !== ef) begin
        n_fail++;
        $display("FAIL pulses cyc=%0d got rise=%b fall=%b want rise=%b fall=%b",
                 cyc, rise, fall, er, ef);
      end
      if (chg != '0) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_commit cyc=%0d clean=%b prev=%b want no change",
                   cyc, clean, prev_clean);
        end else begin
          e = exp_q.pop_front();
          if (cyc != e.cyc || chg !== NCh'(1 << e.ch) || clean[e.ch] !== e.level) begin
            n_fail++;
            $display("FAIL commit got cyc=%0d clean=%b prev=%b want cyc=%0d ch=%0d level=%b",
                     cyc, clean, prev_clean, e.cyc, e.ch, e.level);
          end
        end
      end
    end
    prev_clean = clean;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    sw  = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sw  = '1;
    repeat (3) step();
    n_tests++;
    if (clean !== '0 || busy !== 1'b0 || owner !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_hold got clean=%b busy=%b owner=%0d want 0 0 0", clean, busy, owner);
    end
    rst = 1'b0;
    sw  = '0;
    step();
    n_tests++;
    if (busy !== 1'b0 || clean !== '0) begin
      n_fail++;
      $display("FAIL reset_release got busy=%b clean=%b want 0 0", busy, clean);
    end
  endtask

  task automatic check_drained(input string name);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain got %0d outstanding commits want 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_clean_press();
    int t0;
    apply_reset();
    t0 = cyc;
    sw[0] = 1'b1;
    exp_q.push_back('{cyc: t0 + 51, ch: 0, level: 1'b1});
    for (int k = 1; k <= 55; k++) begin
      step();
      if (k == 1 || k == 25 || k == 50) begin
        n_tests++;
        if (busy !== 1'b1 || owner !== 2'd0) begin
          n_fail++;
          $display("FAIL press_busy k=%0d got busy=%b owner=%0d want 1 0", k, busy, owner);
        end
      end
      if (k == 51) begin
        n_tests++;
        if (busy !== 1'b0 || clean[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL press_done got busy=%b clean0=%b want 0 1", busy, clean[0]);
        end
      end
    end
    check_drained("press");
  endtask

  task automatic test_bounce();
    int t0;
    int t1;
    apply_reset();
    t0 = cyc;
    sw[1] = 1'b1;
    repeat (20) step();
    n_tests++;
    if (busy !== 1'b1 || owner !== 2'd1) begin
      n_fail++;
      $display("FAIL bounce_timing got busy=%b owner=%0d want 1 1", busy, owner);
    end
    sw[1] = 1'b0;
    step();
    n_tests++;
    if (busy !== 1'b0 || clean[1] !== 1'b0 || cyc != t0 + 21) begin
      n_fail++;
      $display("FAIL bounce_abort got busy=%b clean1=%b want 0 0", busy, clean[1]);
    end
    // ptr now sits at 2, so ch3 must win over ch0.
    t1 = cyc;
    sw[0] = 1'b1;
    sw[3] = 1'b1;
    exp_q.push_back('{cyc: t1 + 51, ch: 3, level: 1'b1});
    exp_q.push_back('{cyc: t1 + 102, ch: 0, level: 1'b1});
    step();
    n_tests++;
    if (busy !== 1'b1 || owner !== 2'd3) begin
      n_fail++;
      $display("FAIL bounce_ptr got busy=%b owner=%0d want 1 3", busy, owner);
    end
    repeat (104) step();
    check_drained("bounce");
  endtask

  task automatic test_contention();
    int t0;
    apply_reset();
    t0 = cyc;
    sw[0] = 1'b1;
    sw[2] = 1'b1;
    exp_q.push_back('{cyc: t0 + 51, ch: 0, level: 1'b1});
    exp_q.push_back('{cyc: t0 + 102, ch: 2, level: 1'b1});
    for (int k = 1; k <= 105; k++) begin
      step();
      if (k == 51) begin
        n_tests++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL contention_gap got busy=%b want 0", busy);
        end
      end
      if (k == 52) begin
        n_tests++;
        if (busy !== 1'b1 || owner !== 2'd2) begin
          n_fail++;
          $display("FAIL contention_grant got busy=%b owner=%0d want 1 2", busy, owner);
        end
      end
    end
    check_drained("contention");
  endtask

  task automatic test_fairness();
    int t0;
    apply_reset();
    t0 = cyc;
    sw[3] = 1'b1;
    sw[0] = 1'b1;
    exp_q.push_back('{cyc: t0 + 57, ch: 3, level: 1'b1});
    for (int k = 1; k <= 70; k++) begin
      step();
      sw[0] = (k < 5) || (k >= 6 && k < 40 && (k % 4) >= 2);
      if (k == 1 || k == 7) begin
        n_tests++;
        if (busy !== 1'b1 || owner !== ((k == 1) ? 2'd0 : 2'd3)) begin
          n_fail++;
          $display("FAIL fairness_grant k=%0d got busy=%b owner=%0d want 1 %0d",
                   k, busy, owner, (k == 1) ? 0 : 3);
        end
      end
    end
    n_tests++;
    if (clean !== 4'b1000) begin
      n_fail++;
      $display("FAIL fairness_final got clean=%b want 1000", clean);
    end
    check_drained("fairness");
  endtask

  task automatic test_reset_mid();
    int t0;
    apply_reset();
    t0 = cyc;
    sw[1] = 1'b1;
    repeat (31) step();
    n_tests++;
    if (busy !== 1'b1 || clean[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_before got busy=%b clean1=%b want 1 0", busy, clean[1]);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.push_back('{cyc: t0 + 83, ch: 1, level: 1'b1});
    step();
    n_tests++;
    if (busy !== 1'b1 || owner !== 2'd1) begin
      n_fail++;
      $display("FAIL midrst_regrant got busy=%b owner=%0d want 1 1", busy, owner);
    end
    repeat (53) step();
    check_drained("midrst");
  endtask

  task automatic test_release();
    int t1;
    t1 = cyc;
    sw[1] = 1'b0;
    exp_q.push_back('{cyc: t1 + 51, ch: 1, level: 1'b0});
    repeat (55) step();
    n_tests++;
    if (clean !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL release_final got clean=%b busy=%b want 0000 0", clean, busy);
    end
    check_drained("release");
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_contention();
    test_fairness();
    test_reset_mid();
    test_release();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
